// File: rtl/dac_spi_tx.sv
// SPI transmitter for a 10-bit TLC5615-class DAC: 16-bit frame {4'b0, code, 2'b0}, MSB first,
// with a one-deep, newest-wins pending slot so that no update is lost while a frame is in flight.
module dac_spi_tx #(
    parameter int SCLK_HALF = 5,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int CS_IDLE   = 10
) (
    input  logic       i_clk_50m,
    input  logic       i_rst_n,
    input  logic       i_dac_start,
    input  logic [9:0] i_dac_value,
    output logic       o_dac_cs_n,
    output logic       o_dac_sclk,
    output logic       o_dac_sdi,
    output logic       o_busy,
    output logic       o_done,
    output logic [9:0] o_dac_value_sent
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] HALF_M1  = 8'(SCLK_HALF - 1);
    localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_M1  = 8'(CS_IDLE - 1);

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic [3:0]  bit_cnt_reg;
    logic [15:0] frame_reg;
    logic [9:0]  pend_val_reg;
    logic        pend_reg;
    logic        cs_n_reg;
    logic        sclk_reg;
    logic        sdi_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [9:0]  sent_reg;

    logic [15:0] start_frame;
    logic [15:0] pend_frame;

    assign start_frame = {4'b0000, i_dac_value, 2'b00};
    assign pend_frame  = {4'b0000, pend_val_reg, 2'b00};

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            frame_reg    <= '0;
            pend_val_reg <= '0;
            pend_reg     <= 1'b0;
            cs_n_reg     <= 1'b1;
            sclk_reg     <= 1'b0;
            sdi_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sent_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cs_n_reg <= 1'b1;
                    sclk_reg <= 1'b0;
                    sdi_reg  <= 1'b0;
                    busy_reg <= i_dac_start | pend_reg;
                    // A fresh start is newer than anything left pending, so it wins.
                    if (i_dac_start || pend_reg) begin
                        frame_reg <= i_dac_start ? start_frame : pend_frame;
                        sdi_reg   <= i_dac_start ? start_frame[15] : pend_frame[15];
                        pend_reg  <= 1'b0;
                        state_reg <= ST_SETUP;
                        cs_n_reg  <= 1'b0;
                        cnt_reg   <= SETUP_M1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg   <= ST_SHIFT;
                        cnt_reg     <= HALF_M1;
                        bit_cnt_reg <= 4'd15;
                        sclk_reg    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_reg != 8'd0) begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end else if (!sclk_reg) begin
                        sclk_reg <= 1'b1;
                        cnt_reg  <= HALF_M1;
                    end else if (bit_cnt_reg == 4'd0) begin
                        sclk_reg  <= 1'b0;
                        state_reg <= ST_HOLD;
                        cnt_reg   <= HOLD_M1;
                    end else begin
                        // Falling edge: present the next bit for the DAC's rising-edge sample.
                        sclk_reg    <= 1'b0;
                        sdi_reg     <= frame_reg[bit_cnt_reg - 4'd1];
                        bit_cnt_reg <= bit_cnt_reg - 4'd1;
                        cnt_reg     <= HALF_M1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == 8'd0) begin
                        cs_n_reg  <= 1'b1;
                        sdi_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                        sent_reg  <= frame_reg[11:2];
                        state_reg <= ST_GAP;
                        cnt_reg   <= IDLE_M1;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_reg != 8'd0) begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end else if (pend_reg) begin
                        frame_reg <= pend_frame;
                        sdi_reg   <= pend_frame[15];
                        pend_reg  <= 1'b0;
                        state_reg <= ST_SETUP;
                        cs_n_reg  <= 1'b0;
                        cnt_reg   <= SETUP_M1;
                    end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cs_n_reg  <= 1'b1;
                    sclk_reg  <= 1'b0;
                    sdi_reg   <= 1'b0;
                    busy_reg  <= pend_reg;
                end
            endcase
            // Any start outside IDLE lands in the pending slot; this overrides a same-cycle clear.
            if (i_dac_start && state_reg != ST_IDLE) begin
                pend_val_reg <= i_dac_value;
                pend_reg     <= 1'b1;
                busy_reg     <= 1'b1;
            end
        end
    end

    assign o_dac_cs_n       = cs_n_reg;
    assign o_dac_sclk       = sclk_reg;
    assign o_dac_sdi        = sdi_reg;
    assign o_busy           = busy_reg;
    assign o_done           = done_reg;
    assign o_dac_value_sent = sent_reg;

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Serial transmitter that pushes the 10-bit APD high-voltage code to the external 10-bit SPI DAC (TLC5615-class).
- Sits directly downstream of the temperature-compensation block and consumes its start pulse and 10-bit DAC value.
- Drives CS/SCLK/SDI with a 16-bit frame: 4 zero bits, the 10-bit code, 2 zero bits, MSB first.
- Supports one-deep, newest-wins pending requests so that no update is lost while a frame is in flight.

Parameters:
- SCLK_HALF, 5, i_clk_50m cycles per SCLK half-period (5 gives 5 MHz SCLK); legal range 1..255.
- CS_SETUP, 2, cycles from CS_N fall to the start of the first SCLK low phase; legal range 1..255.
- CS_HOLD, 2, cycles from the end of the last SCLK high phase to CS_N rise; legal range 1..255.
- CS_IDLE, 10, minimum cycles CS_N stays high between frames; legal range 1..255.

Ports:
- i_clk_50m  in  1  system clock, 50 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_dac_start  in  1  one-cycle request to transmit i_dac_value.
- i_dac_value  in  10  DAC code; sampled only in the cycle i_dac_start is high.
- o_dac_cs_n  out  1  DAC chip select, active low.
- o_dac_sclk  out  1  DAC serial clock; idle low.
- o_dac_sdi  out  1  DAC serial data; changes on SCLK falling edge, DAC samples on rising edge.
- o_busy  out  1  high whenever the FSM is not in IDLE, or a request is pending.
- o_done  out  1  one-cycle pulse when CS_N rises at the end of a frame.
- o_dac_value_sent  out  10  last code fully transmitted.

Behaviour:
- Reset (async): FSM = IDLE, counters cleared, pending flag cleared.
  - Output reset values: cs_n = 1, sclk = 0, sdi = 0, busy = 0, done = 0, value_sent = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Request capture:
  - i_dac_start high in IDLE: frame = {4'b0, i_dac_value, 2'b0} is latched and the FSM moves to SETUP. CS_N is low from the next cycle.
  - i_dac_start high in any other state, including the cycle o_done fires: i_dac_value goes into the pending register and the pending flag is set.
  - A later start overwrites the pending value (newest wins). Never more than one frame is queued.
- FSM states:
  - IDLE: CS_N = 1, SCLK = 0. Leave on start or on the pending flag.
  - SETUP: CS_N = 0; SDI = frame[15]; SCLK held low for CS_SETUP cycles, then go to SHIFT.
  - SHIFT: 16 bits. Each bit is SCLK low for SCLK_HALF cycles, then high for SCLK_HALF cycles.
    - SDI updates to the next bit on entry to each low phase, after the first bit.
    - A 4-bit bit counter runs 15 down to 0. After bit 0's high phase, SCLK returns low and the FSM goes to HOLD.
  - HOLD: CS_N = 0, SCLK = 0 for CS_HOLD cycles.
    - Then CS_N = 1 and o_done = 1 for exactly that cycle.
    - o_dac_value_sent = frame[11:2] in the same cycle. Go to GAP.
  - GAP: CS_N = 1 for CS_IDLE cycles, then:
    - pending set: load the pending value, clear the flag, go to SETUP.
    - pending clear: go to IDLE.
  - Illegal state encodings return to IDLE with CS_N = 1.
- Timing, default parameters:
  - CS_N low width = CS_SETUP + 32*SCLK_HALF + CS_HOLD = 164 cycles.
  - First SCLK rising edge occurs CS_SETUP + SCLK_HALF = 7 cycles after CS_N falls.
  - Back-to-back frame period = 164 + CS_IDLE = 174 cycles.
- SDI is 0 outside the CS_N-low window.
- Reset mid-frame: CS_N returns high immediately and the pending request is discarded. The DAC does not latch the partial frame.

Test Plan:
- Reset, then start with value 0x2AA -> CS_N low 164 cycles. Exactly 16 SCLK rising edges; SDI sampled on the rising edges = 0x0AA8. o_done pulses once; o_dac_value_sent = 0x2AA.
- Value 0x3FF -> sampled frame 0x0FFC. Value 0x000 -> 0x0000 with 16 SCLK edges and SDI constantly 0.
- Start 0x100 at cycle 0, start 0x155 at cycle 50, start 0x0F0 at cycle 80 -> two frames only: 0x100 then 0x0F0 (0x155 dropped). Second CS_N fall exactly CS_IDLE = 10 cycles after the first CS_N rise.
- Start asserted in the same cycle as o_done -> captured as pending and transmitted after the GAP. o_busy stays high continuously.
- Assert i_rst_n low at SCLK edge 8 of a frame, with a pending request queued -> CS_N = 1, SCLK = 0, SDI = 0 within the reset assertion. After release: no frame, o_busy = 0, o_dac_value_sent = 0.
- Check timing with SCLK_HALF = 1 and CS_SETUP = CS_HOLD = CS_IDLE = 1 -> SCLK 25 MHz, CS_N low 34 cycles. Frame content still correct.
